fetch_queue: RTL and testbench

//  - Receiving end of the instruction-fetch interface. Captures the fetch stage's {next_pc, instruction} pair every unfrozen cycle into a small FIFO.
//  - Presents the head entry to the decode stage with a valid/ready handshake.
//  - Drives the fetch stage's freeze input when the FIFO cannot accept an entry.
//  - Discards all queued and in-flight wrong-path entries on a taken branch.
//  - Sits between the IF stage and the ID stage, replacing a plain IF/ID register.

---
 rtl/fetch_queue_pkg.sv | 17 +
 rtl/fetch_queue_if.sv | 24 ++
 rtl/fetch_queue_storage.sv | 23 ++
 rtl/fetch_queue.sv | 78 +++++++
 tb/tb_fetch_queue.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared widths and types for the IF->ID fetch queue.
package fetch_queue_pkg;
  localparam int ADDRESS_LEN = 32;
  localparam int DEPTH       = 4;
  localparam int PTR_W       = $clog2(DEPTH);

  typedef logic [ADDRESS_LEN-1:0] addr_t;
  typedef logic [PTR_W-1:0]       ptr_t;
  typedef logic [PTR_W:0]         count_t;

  typedef struct packed {
    addr_t next_pc;
    addr_t instruction;
  } entry_t;

  localparam count_t FULL_COUNT = count_t'(DEPTH);
endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-side and decode-side signals of the fetch queue; slave = the queue itself.
interface fetch_queue_if;
  import fetch_queue_pkg::*;

  addr_t  if_next_pc;
  addr_t  if_instruction;
  logic   branch_taken;
  logic   if_freeze;
  logic   id_valid;
  logic   id_ready;
  addr_t  id_next_pc;
  addr_t  id_instruction;
  count_t count;

  modport slave (
    input  if_next_pc, if_instruction, branch_taken, id_ready,
    output if_freeze, id_valid, id_next_pc, id_instruction, count
  );

  modport master (
    output if_next_pc, if_instruction, branch_taken, id_ready,
    input  if_freeze, id_valid, id_next_pc, id_instruction, count
  );
endinterface

// File: rtl/fetch_queue_storage.sv
// Entry storage: one synchronous write port, one asynchronous read port.
module fetch_queue_storage
  import fetch_queue_pkg::*;
(
  input  logic   clk,
  input  logic   we,
  input  ptr_t   waddr,
  input  entry_t wdata,
  input  ptr_t   raddr,
  output entry_t rdata
);

  entry_t mem_q [DEPTH];

  // NOTE: storage is not reset; validity is tracked by count in the parent,
  // so clearing the array would only cost a reset net on every bit.
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// FIFO between IF and ID: captures every unfrozen fetch word, flushes on a taken branch.
module fetch_queue
  import fetch_queue_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  fetch_queue_if.slave bus
);

  ptr_t   rd_ptr_q, rd_ptr_d;
  ptr_t   wr_ptr_q, wr_ptr_d;
  count_t count_q, count_d;

  logic   id_valid, full, pop, push, freeze;
  entry_t wdata, rdata;

  // NOTE: every signal gets a value at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    id_valid = (count_q != '0);
    full     = (count_q == FULL_COUNT);
    pop      = id_valid & bus.id_ready & ~bus.branch_taken;
    // A same-cycle pop frees a slot, so a full queue only stalls fetch when nothing drains.
    freeze   = full & ~(bus.id_ready & id_valid) & ~bus.branch_taken;
    push     = ~freeze & ~bus.branch_taken & ~rst;

    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;

    if (bus.branch_taken) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + ptr_t'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + ptr_t'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + count_t'(1);
        2'b01:   count_d = count_q - count_t'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wdata.next_pc     = bus.if_next_pc;
  assign wdata.instruction = bus.if_instruction;

  fetch_queue_storage u_storage (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign bus.if_freeze      = freeze;
  assign bus.id_valid       = id_valid;
  assign bus.id_next_pc     = id_valid ? rdata.next_pc     : '0;
  assign bus.id_instruction = id_valid ? rdata.instruction : '0;
  assign bus.count          = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench: directed scenarios with literal expectations plus a random run
// compared every cycle against a queue-based reference model.
module tb_fetch_queue;
  import fetch_queue_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_queue_if bus ();

  fetch_queue dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {next_pc, instruction} pairs.
  logic [63:0] model_q[$];

  always @(posedge clk) begin
    if (rst || bus.branch_taken) begin
      model_q.delete();
    end else begin
      bit can_pop, can_push;
      can_pop  = (model_q.size() != 0) && bus.id_ready;
      can_push = (model_q.size() < DEPTH) || can_pop;
      if (can_pop)  void'(model_q.pop_front());
      if (can_push) model_q.push_back({bus.if_next_pc, bus.if_instruction});
    end
  end

  logic [63:0] exp_head;
  logic        exp_valid, exp_freeze;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_valid  = (model_q.size() != 0);
      exp_head   = exp_valid ? model_q[0] : 64'd0;
      exp_freeze = (model_q.size() == DEPTH) && !bus.id_ready && !bus.branch_taken;
      check("model_count",  64'(bus.count),         64'(model_q.size()));
      check("model_valid",  64'(bus.id_valid),      64'(exp_valid));
      check("model_pc",     64'(bus.id_next_pc),    64'(exp_head[63:32]));
      check("model_instr",  64'(bus.id_instruction), 64'(exp_head[31:0]));
      check("model_freeze", 64'(bus.if_freeze),     64'(exp_freeze));
    end
  end

  task automatic drive(logic r, logic b, logic rdy, logic [31:0] pc, logic [31:0] ins);
    rst                = r;
    bus.branch_taken   = b;
    bus.id_ready       = rdy;
    bus.if_next_pc     = pc;
    bus.if_instruction = ins;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_head(string tag, int cnt, logic [31:0] pc, logic [31:0] ins);
    @(negedge clk);
    check({tag, "_count"}, 64'(bus.count), 64'(cnt));
    check({tag, "_valid"}, 64'(bus.id_valid), 64'(cnt != 0));
    check({tag, "_pc"},    64'(bus.id_next_pc), 64'(pc));
    check({tag, "_instr"}, 64'(bus.id_instruction), 64'(ins));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat[5];
    int w, popped, cyc;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset state
    drive(1, 0, 0, 32'h0, 32'h0);
    tick();
    chk_en = 1'b1;
    expect_head("reset", 0, 32'h0, 32'h0);
    check("reset_freeze", 64'(bus.if_freeze), 64'd0);

    // Free-run with id_ready=1: one entry in flight, each word visible after one edge
    for (int k = 0; k < 3; k++) begin
      drive(0, 0, 1, 32'(4 * (k + 1)), 32'hA000_0000 + 32'(k));
      tick();
      expect_head($sformatf("stream%0d", k), 1, 32'(4 * (k + 1)), 32'hA000_0000 + 32'(k));
      check($sformatf("stream%0d_freeze", k), 64'(bus.if_freeze), 64'd0);
    end
    tick();

    // Decode stalls: fills to DEPTH, then fetch freezes
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 32'h20 + 32'(4 * i), 32'hD000_0000 + 32'(i));
      expect_head($sformatf("stall%0d", i), (i + 1 > 4) ? 4 : i + 1, 32'd12, 32'hA000_0002);
      check($sformatf("stall%0d_freeze", i), 64'(bus.if_freeze), 64'(i >= 3));
      tick();
    end
    drive(0, 0, 1, 32'h40, 32'hD000_0040);
    @(negedge clk);
    check("full_pop_freeze", 64'(bus.if_freeze), 64'd0);
    tick();
    expect_head("full_pop", 4, 32'h20, 32'hD000_0000);

    // Flush while full beats the freeze
    drive(0, 1, 0, 32'h500, 32'h5555_5555);
    @(negedge clk);
    check("flush_full_freeze", 64'(bus.if_freeze), 64'd0);
    tick();
    drive(0, 0, 0, 32'h104, 32'h0000_00B0);
    expect_head("after_full_flush", 0, 32'h0, 32'h0);
    tick();
    expect_head("target", 1, 32'h104, 32'h0000_00B0);

    // Flush with three entries and id_ready=1; flush-cycle word is dropped
    drive(0, 0, 0, 32'h108, 32'h0000_00B1);
    tick();
    drive(0, 0, 0, 32'h10c, 32'h0000_00B2);
    tick();
    drive(0, 1, 1, 32'h999, 32'h9999_9999);
    expect_head("pre_flush3", 3, 32'h104, 32'h0000_00B0);
    check("flush3_freeze", 64'(bus.if_freeze), 64'd0);
    tick();
    drive(0, 0, 0, 32'h200, 32'h0000_0200);
    expect_head("after_flush3", 0, 32'h0, 32'h0);
    tick();
    expect_head("after_flush3_push", 1, 32'h200, 32'h0000_0200);

    // Wrap-around: ten words through with id_ready pattern 1,0,1,1,0
    drive(0, 1, 0, 32'h0, 32'h0);
    tick();
    w = 0; popped = 0; cyc = 0;
    while (popped < 10 && cyc < 200) begin
      drive(0, 0, pat[cyc % 5], 32'h10 + 32'(w), 32'hC000_0000 + 32'(w));
      @(negedge clk);
      if (bus.id_valid && bus.id_ready) begin
        check($sformatf("wrap_order%0d", popped), 64'(bus.id_next_pc), 64'(32'h10 + 32'(popped)));
        popped++;
      end
      if (!bus.if_freeze) w++;
      tick();
      cyc++;
    end
    check("wrap_done", 64'(popped), 64'd10);

    // Reset mid-operation with three entries queued
    drive(0, 1, 0, 32'h0, 32'h0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 32'h300 + 32'(4 * i), 32'hE000_0000 + 32'(i));
      tick();
    end
    expect_head("pre_rst", 3, 32'h300, 32'hE000_0000);
    drive(1, 0, 1, 32'h3ff, 32'h3ff);
    tick();
    drive(0, 0, 0, 32'h400, 32'h0000_0400);
    expect_head("after_rst", 0, 32'h0, 32'h0);
    check("after_rst_freeze", 64'(bus.if_freeze), 64'd0);
    tick();
    expect_head("after_rst_push", 1, 32'h400, 32'h0000_0400);

    // Randomized run; the per-cycle model comparison does the checking
    for (int i = 0; i < 3000; i++) begin
      logic rdy;
      rdy = (i % 600 < 300) ? ($urandom_range(3) == 0) : ($urandom_range(3) != 0);
      drive($urandom_range(127) == 0, $urandom_range(23) == 0, rdy, $urandom, $urandom);
      tick();
    end

    drive(0, 0, 0, 32'h0, 32'h0);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
